pipe_stage_elastic: RTL and testbench
=====================================

Name: pipe_stage_elastic

Overview:
- Generic inter-stage pipeline register (IF/ID, ID/RR, RR/EX, EX/MEM, MEM/WB) with a parametrised payload width.
- Replaces the fixed bank of per-field enable/clear registers with one packed payload. Adds a valid/ready handshake, a flush that squashes only valid bits, an optional skid slot for registered-ready full throughput, and a saturating stall counter for performance debug.
- Stage logic packs its fields (PC, operands, register IDs, EX/Mem/WB control) into data_in and unpacks from data_out.

Parameters:
- DATA_W, 128, payload width in bits (min 1).
- CNT_W, 16, stall-counter width (min 1).
- RST_DATA, 0, payload value loaded on clear.

Ports:
- clock  in  1  stage clock, rising edge.
- clear  in  1  synchronous active-high reset.
- enable  in  1  global stage enable. When low: stage frozen, in_ready=0, out_valid masked to 0.
- flush  in  1  synchronous squash of all held entries (branch/jump redirect).
- in_valid  in  1  upstream has a payload.
- in_ready  out  1  stage accepts a payload this cycle.
- data_in  in  DATA_W  upstream payload.
- out_valid  out  1  payload presented downstream.
- out_ready  in  1  downstream accepts.
- data_out  out  DATA_W  payload presented downstream.
- occupancy  out  2  number of valid entries held (0..2; max 1 without skid).
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0.

Behaviour:
- Reset (clear=1 at a clock edge):
  - main_valid=0, skid_valid=0, data regs=RST_DATA, stall_cnt=0.
  - Resulting outputs: out_valid=0, occupancy=0, data_out=RST_DATA.
  - in_ready follows its combinational definition (1 when enable=1).
  - clear overrides flush, enable and all handshakes.
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Both are evaluated at the rising edge. Latency in→out is 1 cycle.
- Priority at each edge: clear > flush > enable=0 (hold) > normal operation.
- Flush:
  - main_valid and skid_valid go to 0 next cycle.
  - A same-cycle in_fire is discarded.
  - Data regs are unchanged.
  - stall_cnt is unchanged.
- enable=0: no register changes, including stall_cnt.
- Base mode (macro absent), single slot:
  - in_ready = enable & (!main_valid | out_ready). This is a combinational path from out_ready.
  - On in_fire: main data<=data_in, main_valid<=1.
  - Else if out_fire: main_valid<=0.
  - Simultaneous in_fire and out_fire: the new payload replaces the old one; main_valid stays 1 (full throughput).
- data_out = main data. out_valid = enable & main_valid.
- stall_cnt increments when enable & out_valid & !out_ready and not clear/flush. It saturates at 2^CNT_W-1 and does not wrap.
- Payload bits are never modified by the block. No X may propagate from data regs when valid=0 after reset.

Optional Feature:
- PIPE_STAGE_SKID_EN defined: a second (skid) slot is added.
  - in_ready = enable & !skid_valid. This is registered state only; there is no path from out_ready.
  - in_fire with main empty, or main draining (out_fire): load main.
  - in_fire while main holds and !out_ready: load skid, skid_valid<=1.
  - out_fire with skid_valid: main<=skid, skid_valid<=0. Same cycle with in_fire is impossible, because in_ready=0.
  - Ordering is strictly FIFO. occupancy reaches 2. Flush clears both slots.
- PIPE_STAGE_SKID_EN undefined: base mode. No skid storage is synthesised, and occupancy[1] is tied to 0.

Decomposition:
- Shared package pipe_pkg:
  - Default width constants (PIPE_DATA_W_DEF, PIPE_CNT_W_DEF).
  - Occupancy encoding constants (OCC_EMPTY=0, OCC_ONE=1, OCC_TWO=2).
  - Per-boundary payload field offsets, e.g. RR_EX field LSB/width constants for PC, DO1, DO2, EX_Ct, Mem_Ct, WB_Ct.
- Sub-module pipe_slot:
  - One DATA_W data register plus valid bit, with load, invalidate and clear inputs.
  - Instantiated once (main), and a second time (skid) under PIPE_STAGE_SKID_EN.

Test Plan:
- Reset: clear=1 for 2 cycles with in_valid=1, data_in=0xA5 → out_valid=0, occupancy=0, stall_cnt=0, data_out=RST_DATA; in_ready=1 with enable=1.
- Streaming: out_ready=1, enable=1, feed 0x1,0x2,0x3 on consecutive cycles → data_out shows 0x1,0x2,0x3 one cycle later each; no gaps; stall_cnt=0.
- Back-pressure: hold 0x10, out_ready=0 for 5 cycles → data_out stays 0x10, stall_cnt=5. Base mode: in_ready=0. Skid mode: 0x11 accepted and occupancy=2, then in_ready=0; on release, order is 0x10 then 0x11.
- Flush: stage holding 0x20 (skid mode: plus 0x21), assert flush with in_valid=1, data_in=0x22 → next cycle out_valid=0, occupancy=0, 0x22 never appears; stall_cnt unchanged.
- Enable freeze: with 0x30 held, enable=0 for 3 cycles, in_valid=1, out_ready=1 → in_ready=0, out_valid=0, no state change; on enable=1, 0x30 is presented.
- Saturation: CNT_W=3, stall 10 cycles → stall_cnt stops at 7. clear → 0.

Source files
------------

// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared widths, occupancy encoding and per-boundary payload field offsets
package pipe_pkg;

    localparam int PIPE_DATA_W_DEF = 128;
    localparam int PIPE_CNT_W_DEF  = 16;

    localparam logic [1:0] OCC_EMPTY = 2'd0;
    localparam logic [1:0] OCC_ONE   = 2'd1;
    localparam logic [1:0] OCC_TWO   = 2'd2;

    // RR/EX payload layout, LSB-first
    localparam int RR_EX_PC_LSB     = 0;
    localparam int RR_EX_PC_W       = 32;
    localparam int RR_EX_DO1_LSB    = RR_EX_PC_LSB + RR_EX_PC_W;
    localparam int RR_EX_DO1_W      = 32;
    localparam int RR_EX_DO2_LSB    = RR_EX_DO1_LSB + RR_EX_DO1_W;
    localparam int RR_EX_DO2_W      = 32;
    localparam int RR_EX_EX_CT_LSB  = RR_EX_DO2_LSB + RR_EX_DO2_W;
    localparam int RR_EX_EX_CT_W    = 8;
    localparam int RR_EX_MEM_CT_LSB = RR_EX_EX_CT_LSB + RR_EX_EX_CT_W;
    localparam int RR_EX_MEM_CT_W   = 4;
    localparam int RR_EX_WB_CT_LSB  = RR_EX_MEM_CT_LSB + RR_EX_MEM_CT_W;
    localparam int RR_EX_WB_CT_W    = 4;
    localparam int RR_EX_TOTAL_W    = RR_EX_WB_CT_LSB + RR_EX_WB_CT_W;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - one payload register plus valid bit with clear, load and invalidate
module pipe_slot #(
    parameter int                DATA_W   = 128,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              load,
    input  logic              invalidate,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid,
    output logic [DATA_W-1:0] data
);

    // invalidate never touches data so squashed payloads stay observable but unflagged
    always_ff @(posedge clock) begin
        if (clear) begin
            valid <= 1'b0;
            data  <= RST_DATA;
        end else if (load) begin
            valid <= 1'b1;
            data  <= data_in;
        end else if (invalidate) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - elastic pipeline register; PIPE_STAGE_SKID_EN adds a skid slot
module pipe_stage_elastic
    import pipe_pkg::*;
#(
    parameter int                DATA_W   = PIPE_DATA_W_DEF,
    parameter int                CNT_W    = PIPE_CNT_W_DEF,
    parameter logic [DATA_W-1:0] RST_DATA = '0
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              enable,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] data_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              main_valid;
    logic [DATA_W-1:0] main_data;
    logic              main_load;
    logic              main_inv;
    logic [DATA_W-1:0] main_next;
    logic              in_fire;
    logic              out_fire;
    logic              active;

    assign active    = enable & ~flush;
    assign out_valid = enable & main_valid;
    assign out_fire  = out_valid & out_ready;
    assign in_fire   = in_valid & in_ready;
    assign data_out  = main_data;
    assign main_inv  = flush | (active & out_fire);

`ifdef PIPE_STAGE_SKID_EN
    logic              skid_valid;
    logic [DATA_W-1:0] skid_data;
    logic              skid_load;
    logic              skid_inv;

    // ready depends only on skid state, breaking the out_ready -> in_ready path
    assign in_ready  = enable & ~skid_valid;
    assign main_load = active & ((out_fire & skid_valid) | (in_fire & (~main_valid | out_fire)));
    assign main_next = skid_valid ? skid_data : data_in;
    assign skid_load = active & in_fire & main_valid & ~out_fire;
    assign skid_inv  = flush | (active & out_fire);
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

    pipe_slot #(
        .DATA_W   (DATA_W),
        .RST_DATA (RST_DATA)
    ) u_skid (
        .clock      (clock),
        .clear      (clear),
        .load       (skid_load),
        .invalidate (skid_inv),
        .data_in    (data_in),
        .valid      (skid_valid),
        .data       (skid_data)
    );
`else
    assign in_ready  = enable & (~main_valid | out_ready);
    assign main_load = active & in_fire;
    assign main_next = data_in;
    assign occupancy = {1'b0, main_valid};
`endif

    pipe_slot #(
        .DATA_W   (DATA_W),
        .RST_DATA (RST_DATA)
    ) u_main (
        .clock      (clock),
        .clear      (clear),
        .load       (main_load),
        .invalidate (main_inv),
        .data_in    (main_next),
        .valid      (main_valid),
        .data       (main_data)
    );

    always_ff @(posedge clock) begin
        if (clear) begin
            stall_cnt <= '0;
        end else if (active & out_valid & ~out_ready & (stall_cnt != CNT_MAX)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// tb/tb_pipe_stage_elastic.sv - directed scoreboard bench for pipe_stage_elastic
module tb_pipe_stage_elastic;

    localparam int                DATA_W   = 8;
    localparam int                CNT_W    = 3;
    localparam logic [DATA_W-1:0] RST_DATA = 8'h5C;

`ifdef PIPE_STAGE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic              clock = 1'b0;
    logic              clear;
    logic              enable;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] data_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] data_out;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    logic [DATA_W-1:0] exp_item;

    always #5 clock = ~clock;

    pipe_stage_elastic #(
        .DATA_W   (DATA_W),
        .CNT_W    (CNT_W),
        .RST_DATA (RST_DATA)
    ) dut (
        .clock     (clock),
        .clear     (clear),
        .enable    (enable),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_in   (data_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .data_out  (data_out),
        .occupancy (occupancy),
        .stall_cnt (stall_cnt)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // sample handshakes at the falling edge, then advance past the next rising edge
    task automatic tick();
        @(negedge clock);
        if (clear || flush) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                check("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    exp_item = exp_q.pop_front();
                    check("sb_data_out", 32'(data_out), 32'(exp_item));
                end
            end
            if (in_valid && in_ready) exp_q.push_back(data_in);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        clear     = 1'b1;
        enable    = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b1;
        data_in   = 8'hA5;
        out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
        check("rst_data_out", 32'(data_out), 32'h5C);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        clear    = 1'b0;
        in_valid = 1'b0;

        // streaming
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            data_in = 8'(i);
            tick();
            check("stream_valid", 32'(out_valid), 32'd1);
            check("stream_data", 32'(data_out), 32'(i));
        end
        in_valid = 1'b0;
        tick();
        check("stream_drained", 32'(out_valid), 32'd0);
        check("stream_stall_cnt", 32'(stall_cnt), 32'd0);

        // back-pressure
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 8'h10;
        tick();
        data_in = 8'h11;
        for (int i = 0; i < 5; i++) tick();
        check("bp_data_out", 32'(data_out), 32'h10);
        check("bp_stall_cnt", 32'(stall_cnt), 32'd5);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_occupancy", 32'(occupancy), SKID ? 32'd2 : 32'd1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        tick();
        check("bp_drained", 32'(out_valid), 32'd0);
        check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

        // flush
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 8'h20;
        tick();
        data_in = 8'h21;
        tick();
        check("fl_pre_stall", 32'(stall_cnt), 32'd6);
        flush   = 1'b1;
        data_in = 8'h22;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("fl_out_valid", 32'(out_valid), 32'd0);
        check("fl_occupancy", 32'(occupancy), 32'd0);
        check("fl_stall_cnt", 32'(stall_cnt), 32'd6);
        check("fl_data_kept", 32'(data_out), 32'h20);
        out_ready = 1'b1;
        tick();
        tick();
        check("fl_nothing_out", 32'(out_valid), 32'd0);

        // enable freeze
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 8'h30;
        tick();
        enable    = 1'b0;
        data_in   = 8'h31;
        out_ready = 1'b1;
        #1;
        check("en_in_ready", 32'(in_ready), 32'd0);
        check("en_out_valid", 32'(out_valid), 32'd0);
        for (int i = 0; i < 3; i++) tick();
        check("en_stall_cnt", 32'(stall_cnt), 32'd6);
        check("en_occupancy", 32'(occupancy), 32'd1);
        check("en_data_held", 32'(data_out), 32'h30);
        enable   = 1'b1;
        in_valid = 1'b0;
        #1;
        check("en_resume_valid", 32'(out_valid), 32'd1);
        check("en_resume_data", 32'(data_out), 32'h30);
        tick();
        check("en_sb_empty", 32'(exp_q.size()), 32'd0);

        // saturation
        clear = 1'b1;
        tick();
        clear     = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = 8'h40;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        check("sat_stall_cnt", 32'(stall_cnt), 32'd7);
        check("sat_data_out", 32'(data_out), 32'h40);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("sat_clear_cnt", 32'(stall_cnt), 32'd0);
        check("sat_clear_valid", 32'(out_valid), 32'd0);
        check("sat_clear_data", 32'(data_out), 32'h5C);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
